// File: rtl/mips_multicycle_ctrl_if.sv
// Control/datapath bundle for the multi-cycle MIPS controller.
// master = controller side, slave = datapath side.
interface mips_multicycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       link;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       instr_done;
  logic       illegal_op;
  logic       mem_timeout;
  logic [3:0] state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, link, alu_src_a, alu_src_b, alu_op, pc_source,
           instr_done, illegal_op, mem_timeout, state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, link, alu_src_a, alu_src_b, alu_op, pc_source,
           instr_done, illegal_op, mem_timeout, state
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared ALU and one variable-latency memory, aborting stalled accesses.
module mips_multicycle_ctrl #(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mips_multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11,
    S_JR       = 4'd12,
    S_JAL      = 4'd13
  } state_t;

  localparam logic [7:0] WAIT_LIMIT_C = 8'(WAIT_LIMIT);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  state_t     state_q, state_d;
  logic [7:0] wait_q, wait_d;

  logic       mem_state_s, stalled_s, timeout_s;
  logic       pc_write_s, i_or_d_s, mem_read_s, mem_write_s, ir_write_s;
  logic       reg_dst_s, mem_to_reg_s, reg_write_s, link_s, alu_src_a_s;
  logic [1:0] alu_src_b_s, alu_op_s, pc_source_s;
  logic       instr_done_s, illegal_op_s;

  // Stall tracking: counter only survives while a memory state keeps waiting.
  always_comb begin
    mem_state_s = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    stalled_s   = mem_state_s && !bus.mem_ready;
    timeout_s   = stalled_s && (wait_q == WAIT_LIMIT_C);
    if (stalled_s && !timeout_s) begin
      wait_d = wait_q + 8'd1;
    end else begin
      wait_d = 8'd0;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_d      = state_q;
    pc_write_s   = 1'b0;
    i_or_d_s     = 1'b0;
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    reg_dst_s    = 1'b0;
    mem_to_reg_s = 1'b0;
    reg_write_s  = 1'b0;
    link_s       = 1'b0;
    alu_src_a_s  = 1'b0;
    alu_src_b_s  = 2'b00;
    alu_op_s     = 2'b00;
    pc_source_s  = 2'b00;
    instr_done_s = 1'b0;
    illegal_op_s = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read_s  = 1'b1;
        alu_src_b_s = 2'b01;
        if (bus.mem_ready) begin
          ir_write_s = 1'b1;
          pc_write_s = 1'b1;
          state_d    = S_DECODE;
        end else begin
          // A timed-out fetch simply retries from the same PC.
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        alu_src_b_s = 2'b11;
        case (bus.opcode)
          OP_RTYPE: begin
            if (bus.funct == FN_JR) begin
              state_d = S_JR;
            end else begin
              state_d = S_R_EXEC;
            end
          end
          OP_LW, OP_SW:                      state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
          OP_J:                              state_d = S_JUMP;
          OP_JAL:                            state_d = S_JAL;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = S_I_EXEC;
          default: begin
            illegal_op_s = 1'b1;
            state_d      = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
        if (bus.opcode == OP_SW) begin
          state_d = S_MEM_WR;
        end else begin
          state_d = S_MEM_RD;
        end
      end
      S_MEM_RD: begin
        mem_read_s = 1'b1;
        i_or_d_s   = 1'b1;
        if (bus.mem_ready) begin
          state_d = S_MEM_WB;
        end else if (timeout_s) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_MEM_RD;
        end
      end
      S_MEM_WB: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = 1'b1;
        instr_done_s = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write_s = 1'b1;
        i_or_d_s    = 1'b1;
        if (bus.mem_ready) begin
          instr_done_s = 1'b1;
          state_d      = S_FETCH;
        end else if (timeout_s) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_MEM_WR;
        end
      end
      S_R_EXEC: begin
        alu_src_a_s = 1'b1;
        alu_op_s    = 2'b10;
        state_d     = S_R_WB;
      end
      S_R_WB: begin
        reg_write_s  = 1'b1;
        reg_dst_s    = 1'b1;
        instr_done_s = 1'b1;
        state_d      = S_FETCH;
      end
      S_I_EXEC: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
        alu_op_s    = 2'b11;
        state_d     = S_I_WB;
      end
      S_I_WB: begin
        reg_write_s  = 1'b1;
        instr_done_s = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_s  = 1'b1;
        alu_op_s     = 2'b01;
        pc_source_s  = 2'b01;
        instr_done_s = 1'b1;
        if (bus.opcode == OP_BNE) begin
          pc_write_s = ~bus.zero;
        end else begin
          pc_write_s = bus.zero;
        end
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pc_write_s   = 1'b1;
        pc_source_s  = 2'b10;
        instr_done_s = 1'b1;
        state_d      = S_FETCH;
      end
      S_JAL: begin
        pc_write_s   = 1'b1;
        pc_source_s  = 2'b10;
        reg_write_s  = 1'b1;
        link_s       = 1'b1;
        instr_done_s = 1'b1;
        state_d      = S_FETCH;
      end
      S_JR: begin
        alu_src_a_s  = 1'b1;
        pc_write_s   = 1'b1;
        pc_source_s  = 2'b11;
        instr_done_s = 1'b1;
        state_d      = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // State and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Strobes are gated by rst_n so nothing leaks while reset is held.
  assign bus.pc_write    = rst_n & pc_write_s;
  assign bus.i_or_d      = rst_n & i_or_d_s;
  assign bus.mem_read    = rst_n & mem_read_s;
  assign bus.mem_write   = rst_n & mem_write_s;
  assign bus.ir_write    = rst_n & ir_write_s;
  assign bus.reg_dst     = rst_n & reg_dst_s;
  assign bus.mem_to_reg  = rst_n & mem_to_reg_s;
  assign bus.reg_write   = rst_n & reg_write_s;
  assign bus.link        = rst_n & link_s;
  assign bus.alu_src_a   = rst_n & alu_src_a_s;
  assign bus.alu_src_b   = rst_n ? alu_src_b_s : 2'b00;
  assign bus.alu_op      = rst_n ? alu_op_s : 2'b00;
  assign bus.pc_source   = rst_n ? pc_source_s : 2'b00;
  assign bus.instr_done  = rst_n & instr_done_s;
  assign bus.illegal_op  = rst_n & illegal_op_s;
  assign bus.mem_timeout = rst_n & timeout_s;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: latency table, directed corner
// sequences and random instruction streams against an instruction-level planner.
module tb_mips_multicycle_ctrl;

  localparam int WAIT_LIMIT = 15;

  logic clk;
  logic rst_n;
  mips_multicycle_ctrl_if bus ();

  mips_multicycle_ctrl #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, link, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       instr_done, illegal_op, mem_timeout;
  } out_t;

  // One expected clock cycle: inputs to apply plus the state/outputs required.
  typedef struct packed {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    logic       mr;
    logic [3:0] st;
    out_t       o;
  } rec_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         lat;
    logic [3:0] st3;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  rec_t q[$];

  function automatic out_t sample();
    out_t s;
    s.pc_write    = bus.pc_write;
    s.i_or_d      = bus.i_or_d;
    s.mem_read    = bus.mem_read;
    s.mem_write   = bus.mem_write;
    s.ir_write    = bus.ir_write;
    s.reg_dst     = bus.reg_dst;
    s.mem_to_reg  = bus.mem_to_reg;
    s.reg_write   = bus.reg_write;
    s.link        = bus.link;
    s.alu_src_a   = bus.alu_src_a;
    s.alu_src_b   = bus.alu_src_b;
    s.alu_op      = bus.alu_op;
    s.pc_source   = bus.pc_source;
    s.instr_done  = bus.instr_done;
    s.illegal_op  = bus.illegal_op;
    s.mem_timeout = bus.mem_timeout;
    return s;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, got, exp);
    end
  endtask

  function automatic rec_t mk(input logic [5:0] op, input logic [5:0] fn, input logic z,
                              input logic [3:0] st);
    rec_t r;
    r    = '0;
    r.op = op;
    r.fn = fn;
    r.z  = z;
    r.st = st;
    r.mr = 1'($urandom_range(1, 0));
    return r;
  endfunction

  // A memory access: 'stall' not-ready cycles, aborted once the stall exceeds the limit.
  task automatic mem_phase(input rec_t base, input int stall, input out_t done_extra, output bit aborted);
    rec_t r;
    int   nst;
    aborted = (stall > WAIT_LIMIT);
    nst     = aborted ? WAIT_LIMIT + 1 : stall;
    for (int i = 0; i < nst; i++) begin
      r               = base;
      r.mr            = 1'b0;
      r.o.mem_timeout = aborted && (i == nst - 1);
      q.push_back(r);
    end
    if (!aborted) begin
      r    = base;
      r.mr = 1'b1;
      r.o  = r.o | done_extra;
      q.push_back(r);
    end
  endtask

  // Expand one instruction into its expected cycle-by-cycle behaviour.
  task automatic plan(input logic [5:0] op, input logic [5:0] fn, input logic z,
                      input int fstall, input int mstall);
    rec_t r;
    out_t e;
    bit   ab;
    r                = mk(op, fn, z, 4'd0);
    r.o.mem_read     = 1'b1;
    r.o.alu_src_b    = 2'b01;
    e                = '0;
    e.ir_write       = 1'b1;
    e.pc_write       = 1'b1;
    mem_phase(r, fstall, e, ab);
    if (ab) mem_phase(r, 0, e, ab);

    r             = mk(op, fn, z, 4'd1);
    r.o.alu_src_b = 2'b11;
    case (op)
      6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B: r.o.illegal_op = 1'b0;
      default: r.o.illegal_op = 1'b1;
    endcase
    q.push_back(r);
    e = '0;
    case (op)
      6'h00: begin
        if (fn == 6'h08) begin
          r = mk(op, fn, z, 4'd12);
          r.o.alu_src_a = 1'b1; r.o.pc_write = 1'b1; r.o.pc_source = 2'b11; r.o.instr_done = 1'b1;
          q.push_back(r);
        end else begin
          r = mk(op, fn, z, 4'd6);
          r.o.alu_src_a = 1'b1; r.o.alu_op = 2'b10;
          q.push_back(r);
          r = mk(op, fn, z, 4'd7);
          r.o.reg_write = 1'b1; r.o.reg_dst = 1'b1; r.o.instr_done = 1'b1;
          q.push_back(r);
        end
      end
      6'h08, 6'h0A, 6'h0C, 6'h0D: begin
        r = mk(op, fn, z, 4'd10);
        r.o.alu_src_a = 1'b1; r.o.alu_src_b = 2'b10; r.o.alu_op = 2'b11;
        q.push_back(r);
        r = mk(op, fn, z, 4'd11);
        r.o.reg_write = 1'b1; r.o.instr_done = 1'b1;
        q.push_back(r);
      end
      6'h23, 6'h2B: begin
        r = mk(op, fn, z, 4'd2);
        r.o.alu_src_a = 1'b1; r.o.alu_src_b = 2'b10;
        q.push_back(r);
        if (op == 6'h23) begin
          r = mk(op, fn, z, 4'd3);
          r.o.mem_read = 1'b1; r.o.i_or_d = 1'b1;
          mem_phase(r, mstall, e, ab);
          if (!ab) begin
            r = mk(op, fn, z, 4'd4);
            r.o.reg_write = 1'b1; r.o.mem_to_reg = 1'b1; r.o.instr_done = 1'b1;
            q.push_back(r);
          end
        end else begin
          r = mk(op, fn, z, 4'd5);
          r.o.mem_write = 1'b1; r.o.i_or_d = 1'b1;
          e.instr_done = 1'b1;
          mem_phase(r, mstall, e, ab);
        end
      end
      6'h04, 6'h05: begin
        r = mk(op, fn, z, 4'd8);
        r.o.alu_src_a = 1'b1; r.o.alu_op = 2'b01; r.o.pc_source = 2'b01; r.o.instr_done = 1'b1;
        r.o.pc_write = (op == 6'h04) ? z : ~z;
        q.push_back(r);
      end
      6'h02, 6'h03: begin
        r = mk(op, fn, z, (op == 6'h02) ? 4'd9 : 4'd13);
        r.o.pc_write = 1'b1; r.o.pc_source = 2'b10; r.o.instr_done = 1'b1;
        r.o.reg_write = (op == 6'h03); r.o.link = (op == 6'h03);
        q.push_back(r);
      end
      default: ;
    endcase
  endtask

  // Apply queued cycles; caller must be positioned at a falling edge.
  task automatic run_plan(input string tag);
    rec_t r;
    while (q.size() > 0) begin
      r             = q.pop_front();
      bus.opcode    = r.op;
      bus.funct     = r.fn;
      bus.zero      = r.z;
      bus.mem_ready = r.mr;
      #1;
      cyc++;
      chk({tag, ".state"}, cyc, 32'(bus.state), 32'(r.st));
      chk({tag, ".outs"}, cyc, 32'(sample()), 32'(r.o));
      @(negedge clk);
    end
  endtask

  vec_t       vecs[14];
  logic [5:0] ops[13];
  int         fopts[6];
  int         mopts[6];

  initial begin
    int         n;
    bit         done;
    logic [3:0] st3;
    out_t       e;

    vecs[0]  = '{6'h00, 6'h20, 1'b0, 4, 4'd6};
    vecs[1]  = '{6'h00, 6'h08, 1'b0, 3, 4'd12};
    vecs[2]  = '{6'h23, 6'h00, 1'b0, 5, 4'd2};
    vecs[3]  = '{6'h2B, 6'h00, 1'b0, 4, 4'd2};
    vecs[4]  = '{6'h04, 6'h00, 1'b1, 3, 4'd8};
    vecs[5]  = '{6'h05, 6'h00, 1'b0, 3, 4'd8};
    vecs[6]  = '{6'h02, 6'h00, 1'b0, 3, 4'd9};
    vecs[7]  = '{6'h03, 6'h00, 1'b0, 3, 4'd13};
    vecs[8]  = '{6'h08, 6'h00, 1'b0, 4, 4'd10};
    vecs[9]  = '{6'h0A, 6'h00, 1'b0, 4, 4'd10};
    vecs[10] = '{6'h0C, 6'h00, 1'b0, 4, 4'd10};
    vecs[11] = '{6'h0D, 6'h00, 1'b0, 4, 4'd10};
    vecs[12] = '{6'h3F, 6'h00, 1'b0, 2, 4'd0};
    vecs[13] = '{6'h01, 6'h00, 1'b0, 2, 4'd0};
    ops   = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h3F, 6'h11};
    fopts = '{0, 0, 0, 1, 3, 16};
    mopts = '{0, 1, 3, 15, 16, 20};

    rst_n         = 1'b0;
    bus.opcode    = 6'h00;
    bus.funct     = 6'h20;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset.state", 0, 32'(bus.state), 32'd0);
    chk("reset.outs", 0, 32'(sample()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed sequences: add, lw with stalls, branches, jal, store timeout and
    // just-in-time completion, illegal opcode, fetch timeout with retry.
    plan(6'h00, 6'h20, 1'b0, 0, 0);
    plan(6'h23, 6'h00, 1'b0, 0, 3);
    plan(6'h04, 6'h00, 1'b1, 0, 0);
    plan(6'h04, 6'h00, 1'b0, 0, 0);
    plan(6'h05, 6'h00, 1'b1, 0, 0);
    plan(6'h03, 6'h00, 1'b0, 0, 0);
    plan(6'h2B, 6'h00, 1'b0, 0, 16);
    plan(6'h2B, 6'h00, 1'b0, 0, 15);
    plan(6'h3F, 6'h00, 1'b0, 0, 0);
    plan(6'h00, 6'h2A, 1'b0, 16, 0);
    plan(6'h23, 6'h00, 1'b0, 0, 16);
    run_plan("dir");

    // Latency table with memory always ready.
    bus.mem_ready = 1'b1;
    foreach (vecs[i]) begin
      bus.opcode = vecs[i].op;
      bus.funct  = vecs[i].fn;
      bus.zero   = vecs[i].z;
      n    = 0;
      done = 1'b0;
      st3  = 4'd0;
      while (!done && n < 12) begin
        #1;
        n++;
        if (n == 3) st3 = bus.state;
        if (bus.instr_done || bus.illegal_op) done = 1'b1;
        @(negedge clk);
      end
      chk("lat", i, done ? 32'(n) : 32'hFFFF_FFFF, 32'(vecs[i].lat));
      if (vecs[i].lat >= 3) chk("path", i, 32'(st3), 32'(vecs[i].st3));
    end

    // Random instruction streams with random stalls.
    for (int k = 0; k < 60; k++) begin
      plan(ops[$urandom_range(12, 0)],
           ($urandom_range(3, 0) == 0) ? 6'h08 : 6'($urandom_range(63, 0)),
           1'($urandom_range(1, 0)),
           fopts[$urandom_range(5, 0)], mopts[$urandom_range(5, 0)]);
      run_plan("rnd");
    end

    // Asynchronous reset in the middle of a stalled load.
    bus.opcode    = 6'h23;
    bus.funct     = 6'h00;
    bus.mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    bus.mem_ready = 1'b0;
    #1;
    chk("arst.pre_state", 0, 32'(bus.state), 32'd3);
    chk("arst.pre_rd", 0, 32'({bus.mem_read, bus.i_or_d}), 32'b11);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst.state", 0, 32'(bus.state), 32'd0);
    chk("arst.outs", 0, 32'(sample()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    e           = '0;
    e.mem_read  = 1'b1;
    e.alu_src_b = 2'b01;
    chk("arst.rel_state", 0, 32'(bus.state), 32'd0);
    chk("arst.rel_outs", 0, 32'(sample()), 32'(e));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Multi-cycle control FSM that sequences a shared-ALU, single-memory MIPS datapath through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK. It replaces the single-cycle control_unit/ALU_CU pair when the datapath moves to one unified memory with variable latency. It drives all datapath mux selects and write strobes each cycle. It waits on a memory-ready handshake and aborts stalled accesses after a bounded wait.

Parameters:
WAIT_LIMIT, 15, maximum consecutive cycles with mem_ready=0 in a memory state before abort (1..255)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
opcode  input  6  Instruction[31:26] from instruction register
funct  input  6  Instruction[5:0] from instruction register
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes current access this cycle
pc_write  output  1  PC load enable
i_or_d  output  1  memory address select: 0=PC, 1=ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  instruction register load
reg_dst  output  1  write register select: 0=rt, 1=rd
mem_to_reg  output  1  write data select: 0=ALUOut, 1=MDR
reg_write  output  1  register file write enable
link  output  1  force write register 31, write data = PC (jal)
alu_src_a  output  1  0=PC, 1=register A
alu_src_b  output  2  00=register B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
alu_op  output  2  00=add, 01=sub, 10=decode funct, 11=decode opcode (immediate ops)
pc_source  output  2  00=ALU result, 01=ALUOut, 10={PC[31:28],target,2'b00}, 11=register A
instr_done  output  1  one-cycle pulse in final cycle of a completed instruction
illegal_op  output  1  one-cycle pulse on unsupported opcode
mem_timeout  output  1  one-cycle pulse on memory wait abort
state  output  4  current state code (debug)

Behaviour:
- Reset (rst_n=0, asynchronous): state=FETCH(0), wait counter=0; while rst_n=0 every output except state is forced to 0.
- Outputs are combinational from state, plus mem_ready/zero/opcode where noted. Only state and wait counter are registered.
- State codes: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, I_EXEC 10, I_WB 11, JR 12, JAL 13.
- Unlisted outputs are 0 in every state.
- FETCH:
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - When mem_ready=1: ir_write=1, pc_write=1, next state DECODE. Otherwise stay in FETCH.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
  - Next state by opcode: 0x00 goes to JR if funct=0x08, else R_EXEC. 0x23/0x2B go to MEM_ADDR. 0x04/0x05 go to BRANCH. 0x02 goes to JUMP. 0x03 goes to JAL. 0x08/0x0A/0x0C/0x0D go to I_EXEC.
  - Any other opcode: illegal_op=1, next state FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state MEM_RD for 0x23, MEM_WR for 0x2B.
- MEM_RD: mem_read=1, i_or_d=1. On mem_ready=1, next state MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Next state FETCH.
- MEM_WR: mem_write=1, i_or_d=1. On mem_ready=1: instr_done=1, next state FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next state R_WB.
- R_WB: reg_write=1, reg_dst=1, instr_done=1. Next state FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=11. Next state I_WB.
- I_WB: reg_write=1, reg_dst=0, instr_done=1. Next state FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, instr_done=1.
  - pc_write = zero for 0x04, ~zero for 0x05.
  - Next state FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1. Next state FETCH.
- JAL: pc_write=1, pc_source=10, reg_write=1, link=1, instr_done=1. Next state FETCH. Link value is the already-incremented PC.
- JR: alu_src_a=1, pc_write=1, pc_source=11, instr_done=1. Next state FETCH.
- Latency with mem_ready tied high:
  - 3 cycles: beq/bne/j/jal/jr.
  - 4 cycles: R-type/I-type/sw.
  - 5 cycles: lw.
  - 2 cycles: illegal opcode.
- Wait counter (8 bits):
  - Increments each cycle in FETCH/MEM_RD/MEM_WR with mem_ready=0.
  - Clears on mem_ready=1 and on any state change.
  - On the cycle the counter equals WAIT_LIMIT with mem_ready still 0: mem_timeout=1, access strobes remain asserted that cycle, and next state is FETCH with counter cleared.
  - A timeout in FETCH re-enters FETCH, i.e. the fetch is retried; pc_write is not asserted. No instr_done.
- mem_ready=1 in the same cycle the counter reaches WAIT_LIMIT: completion wins, no mem_timeout.
- mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
- rst_n asserted mid-instruction: state returns to FETCH immediately and no strobes are issued after release until the normal FETCH sequence.

Test Plan:
- Reset held, then released with mem_ready=1, opcode=0x00, funct=0x20 -> states 0,1,6,7,0. reg_dst=1 and reg_write=1 only in state 7; instr_done pulses once at cycle 4.
- lw (0x23), mem_ready low 3 cycles in MEM_RD -> state 3 held 4 cycles with mem_read=1, i_or_d=1. Then state 4 with mem_to_reg=1, reg_write=1; total 8 cycles.
- beq (0x04) with zero=1 and zero=0, then bne (0x05) with zero=1 -> in state 8, pc_write=1, 0, 0 respectively; pc_source=01 in all cases.
- jal (0x03) -> states 0,1,13. In state 13: pc_write=1, pc_source=10, reg_write=1, link=1.
- WAIT_LIMIT=15, mem_ready=0 in MEM_WR -> mem_timeout pulses on the 16th MEM_WR cycle, then FETCH, with no instr_done. Repeat with mem_ready=1 on that cycle -> no timeout, instr_done=1.
- opcode=0x3F in DECODE -> illegal_op=1 for one cycle, next state 0. Separately, assert rst_n=0 in state 3 -> state=0 and all strobes 0 immediately, without waiting for a clock edge.
